// File: rtl/cw_pkg.sv
// rtl/cw_pkg.sv - shared codeword parameters and FSM state encoding
// Used by both the encoder and the decoder side of the codeword link.
package cw_pkg;

   localparam int CW_W_DEF      = 10;
   localparam int U_DEF         = 4;
   localparam int QMAX_DEF      = 63;
   localparam int NUM_WORDS_DEF = 10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PREFIX = 3'd1,
      ST_SUFFIX = 3'd2,
      ST_EMIT   = 3'd3,
      ST_FIN    = 3'd4
   } cw_state_t;

endpackage

// File: rtl/encoder_main_if.sv
// rtl/encoder_main_if.sv - serial bit input, codeword output and control bundle
// master is the host/FIFO side, slave is the encoder.
interface encoder_main_if
   import cw_pkg::*;
#(
   parameter int CW_W = CW_W_DEF
) ();

   logic            start;
   logic            bin_msg;
   logic            bin_valid;
   logic            bin_ready;
   logic            fifo_full;
   logic [CW_W-1:0] cw_word;
   logic            cw_wr;
   logic            done;

   modport master (
      output start, bin_msg, bin_valid, fifo_full,
      input  bin_ready, cw_word, cw_wr, done
   );

   modport slave (
      input  start, bin_msg, bin_valid, fifo_full,
      output bin_ready, cw_word, cw_wr, done
   );

endinterface

// File: rtl/encoder_main.sv
// rtl/encoder_main.sv - unary-prefix / binary-suffix codeword encoder
// Quotient is sent as a run of ones ended by a zero (or saturating at QMAX), then U remainder bits MSB-first.
module encoder_main
   import cw_pkg::*;
#(
   parameter int CW_W      = CW_W_DEF,
   parameter int U         = U_DEF,
   parameter int QMAX      = QMAX_DEF,
   parameter int NUM_WORDS = NUM_WORDS_DEF
) (
   input logic            clk,
   input logic            rst_b,
   encoder_main_if.slave  bus
);

   localparam int QW  = (QMAX < 1) ? 1 : $clog2(QMAX + 1);
   localparam int WCW = $clog2(NUM_WORDS + 1);
   localparam int SCW = $clog2(U + 1);

   logic [1:0]      rst_sync_q;
   logic            rst_n;

   cw_state_t       state_q, state_d;
   logic [QW-1:0]   q_q, q_d;
   logic [U-1:0]    r_q, r_d;
   logic [SCW-1:0]  sfx_q, sfx_d;
   logic [WCW-1:0]  wc_q, wc_d;
   logic [CW_W-1:0] cw_word_q, cw_word_d;
   logic            bin_ready_q, bin_ready_d;
   logic            done_q, done_d;
   logic            accept;

   // Reset asserts immediately but releases on a clock edge, so the FSM never sees a partial release cycle.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n  = rst_sync_q[1];
   assign accept = bus.bin_valid && bin_ready_q;

   always_comb begin
      state_d   = state_q;
      q_d       = q_q;
      r_d       = r_q;
      sfx_d     = sfx_q;
      wc_d      = wc_q;
      cw_word_d = cw_word_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_PREFIX;
               q_d     = '0;
               r_d     = '0;
               sfx_d   = '0;
               wc_d    = '0;
            end
         end
         ST_PREFIX: begin
            if (q_q == QW'(QMAX)) begin
               state_d = ST_SUFFIX;
            end else if (accept) begin
               if (bus.bin_msg) begin
                  q_d = q_q + QW'(1);
               end else begin
                  state_d = ST_SUFFIX;
               end
            end
         end
         ST_SUFFIX: begin
            if (accept) begin
               r_d = U'({r_q, bus.bin_msg});
               if (sfx_q == SCW'(U - 1)) begin
                  state_d   = ST_EMIT;
                  sfx_d     = '0;
                  cw_word_d = (CW_W'(q_q) << U) | CW_W'(r_d);
               end else begin
                  sfx_d = sfx_q + SCW'(1);
               end
            end
         end
         ST_EMIT: begin
            if (!bus.fifo_full) begin
               wc_d    = wc_q + WCW'(1);
               q_d     = '0;
               r_d     = '0;
               state_d = (wc_d < WCW'(NUM_WORDS)) ? ST_PREFIX : ST_FIN;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Ready is decoded from the next state so it is a flop output with no path from bin_valid.
      bin_ready_d = ((state_d == ST_PREFIX) && (q_d != QW'(QMAX))) || (state_d == ST_SUFFIX);
      done_d      = (state_d == ST_FIN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         q_q         <= '0;
         r_q         <= '0;
         sfx_q       <= '0;
         wc_q        <= '0;
         cw_word_q   <= '0;
         bin_ready_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         q_q         <= q_d;
         r_q         <= r_d;
         sfx_q       <= sfx_d;
         wc_q        <= wc_d;
         cw_word_q   <= cw_word_d;
         bin_ready_q <= bin_ready_d;
         done_q      <= done_d;
      end
   end

   // The write strobe follows fifo_full in the same cycle so a word is never pushed into a full FIFO.
   assign bus.cw_wr     = (state_q == ST_EMIT) && !bus.fifo_full;
   assign bus.cw_word   = cw_word_q;
   assign bus.bin_ready = bin_ready_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_encoder_main.sv
// tb/tb_encoder_main.sv - directed bench for encoder_main
module tb_encoder_main;

   logic clk = 1'b0;
   logic rst_b;

   encoder_main_if #(.CW_W(10)) bus ();

   encoder_main dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int consumed = 0;
   int stalls   = 0;
   int wr_cnt   = 0;
   int done_cnt = 0;
   int wr_cyc   = 0;
   int done_cyc = 0;
   logic [9:0] last_word = '0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (bus.bin_valid && bus.bin_ready) consumed++;
      if (bus.bin_valid && !bus.bin_ready) stalls++;
      if (bus.cw_wr) begin
         wr_cnt++;
         last_word = bus.cw_word;
         wr_cyc    = cyc;
      end
      if (bus.done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic b, input bit gaps);
      int  n;
      bit  taken;
      if (gaps) begin
         n = $urandom_range(0, 2);
         repeat (n) begin
            @(posedge clk);
            #1;
         end
      end
      bus.bin_msg   = b;
      bus.bin_valid = 1'b1;
      taken         = 1'b0;
      for (int i = 0; i < 300 && !taken; i++) begin
         @(negedge clk);
         if (bus.bin_ready) taken = 1'b1;
      end
      if (taken) begin
         @(posedge clk);
         #1;
      end else begin
         check_eq("bit_accept_timeout", 0, 1);
      end
      bus.bin_valid = 1'b0;
   endtask

   task automatic send_word(input int q, input logic [3:0] r, input bit gaps);
      for (int i = 0; i < q; i++) send_bit(1'b1, gaps);
      if (q < 63) send_bit(1'b0, gaps);
      for (int b = 3; b >= 0; b--) send_bit(r[b], gaps);
   endtask

   task automatic wait_wr(input int target);
      for (int i = 0; i < 60 && wr_cnt < target; i++) @(posedge clk);
      #1;
      check_eq("wr_wait", wr_cnt, target);
   endtask

   task automatic start_msg(input bit with_bit);
      @(posedge clk);
      #1;
      bus.start     = 1'b1;
      bus.bin_valid = with_bit;
      bus.bin_msg   = 1'b1;
      @(posedge clk);
      #1;
      bus.start     = 1'b0;
      bus.bin_valid = 1'b0;
   endtask

   initial begin
      int c0, s0, w0, d0;
      rst_b         = 1'b1;
      bus.start     = 1'b0;
      bus.bin_msg   = 1'b0;
      bus.bin_valid = 1'b0;
      bus.fifo_full = 1'b0;
      #1 rst_b = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_cw_word", bus.cw_word, 0);
      check_eq("rst_cw_wr", bus.cw_wr, 0);
      check_eq("rst_bin_ready", bus.bin_ready, 0);
      check_eq("rst_done", bus.done, 0);
      rst_b = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_eq("idle_bin_ready", bus.bin_ready, 0);

      // message 1: start with a bit presented in the same cycle
      w0 = wr_cnt;
      d0 = done_cnt;
      c0 = consumed;
      start_msg(1'b1);
      check_eq("start_bit_not_taken", consumed - c0, 0);

      c0 = consumed;
      send_word(2, 4'd5, 1'b0);
      wait_wr(w0 + 1);
      check_eq("w1_word", last_word, 37);
      check_eq("w1_consumed", consumed - c0, 7);

      c0 = consumed;
      send_word(0, 4'd0, 1'b0);
      wait_wr(w0 + 2);
      check_eq("w2_word", last_word, 0);
      check_eq("w2_consumed", consumed - c0, 5);

      c0 = consumed;
      s0 = stalls;
      send_word(63, 4'd15, 1'b0);
      wait_wr(w0 + 3);
      check_eq("w3_word", last_word, 1023);
      check_eq("w3_consumed", consumed - c0, 67);
      check_eq("w3_ready_low_cycles", stalls - s0, 1);

      bus.fifo_full = 1'b1;
      send_word(1, 4'd12, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check_eq("full_cw_wr", bus.cw_wr, 0);
         check_eq("full_bin_ready", bus.bin_ready, 0);
         check_eq("full_cw_word", bus.cw_word, 28);
      end
      check_eq("full_no_write", wr_cnt - w0, 3);
      @(posedge clk);
      #1;
      bus.fifo_full = 1'b0;
      wait_wr(w0 + 4);
      check_eq("w4_word", last_word, 28);

      send_word(3, 4'd9, 1'b1);
      wait_wr(w0 + 5);
      check_eq("w5_word", last_word, 57);

      @(posedge clk);
      #1;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;

      send_word(0, 4'd15, 1'b1);
      wait_wr(w0 + 6);
      check_eq("w6_word", last_word, 15);
      send_word(5, 4'd0, 1'b1);
      wait_wr(w0 + 7);
      check_eq("w7_word", last_word, 80);
      send_word(1, 4'd1, 1'b1);
      wait_wr(w0 + 8);
      check_eq("w8_word", last_word, 17);
      send_word(7, 4'd6, 1'b1);
      wait_wr(w0 + 9);
      check_eq("w9_word", last_word, 118);
      send_word(2, 4'd10, 1'b1);
      wait_wr(w0 + 10);
      check_eq("w10_word", last_word, 42);

      repeat (4) @(posedge clk);
      #1;
      check_eq("msg_wr_count", wr_cnt - w0, 10);
      check_eq("msg_done_count", done_cnt - d0, 1);
      check_eq("done_latency", done_cyc - wr_cyc, 1);
      check_eq("after_done_ready", bus.bin_ready, 0);
      check_eq("after_done_word", bus.cw_word, 42);

      // message 2: reset in the suffix of word 3
      w0 = wr_cnt;
      start_msg(1'b0);
      send_word(1, 4'd3, 1'b0);
      wait_wr(w0 + 1);
      check_eq("m2_w1_word", last_word, 19);
      send_word(0, 4'd7, 1'b0);
      wait_wr(w0 + 2);
      check_eq("m2_w2_word", last_word, 7);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      rst_b = 1'b0;
      #1;
      check_eq("mid_rst_cw_word", bus.cw_word, 0);
      check_eq("mid_rst_cw_wr", bus.cw_wr, 0);
      check_eq("mid_rst_bin_ready", bus.bin_ready, 0);
      check_eq("mid_rst_done", bus.done, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_b = 1'b1;
      w0 = wr_cnt;
      d0 = done_cnt;
      c0 = consumed;
      bus.bin_msg = 1'b1;
      for (int k = 0; k < 20; k++) begin
         bus.bin_valid = k[0];
         @(posedge clk);
         #1;
      end
      bus.bin_valid = 1'b0;
      check_eq("post_rst_no_wr", wr_cnt - w0, 0);
      check_eq("post_rst_no_done", done_cnt - d0, 0);
      check_eq("post_rst_no_consume", consumed - c0, 0);

      start_msg(1'b0);
      send_word(4, 4'd2, 1'b0);
      wait_wr(w0 + 1);
      check_eq("post_rst_w1_word", last_word, 66);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule

// File: doc/encoder_main.md
ENCODER_MAIN -- requirements
Module: encoder_main

Interface
REQ-001 SHALL have parameter CW_W, default 10, meaning codeword width in bits.
REQ-002 SHALL have parameter U, default 4, meaning suffix (remainder) bit count; the divisor is 2^U.
REQ-003 SHALL have parameter QMAX, default 63, meaning the quotient saturation value, with QMAX*2^U + 2^U-1 <= 2^CW_W-1.
REQ-004 SHALL have parameter NUM_WORDS, default 10, meaning the number of codewords per message.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst_b, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1 bit: a one-cycle pulse that begins a message.
REQ-008 SHALL have port bin_msg, input, 1 bit: serial message bit.
REQ-009 SHALL have port bin_valid, input, 1 bit: bin_msg is valid.
REQ-010 SHALL have port bin_ready, output, 1 bit: the encoder accepts a bit this cycle.
REQ-011 SHALL have port fifo_full, input, 1 bit: the downstream codeword FIFO is full.
REQ-012 SHALL have port cw_word, output, CW_W bits: the encoded codeword.
REQ-013 SHALL have port cw_wr, output, 1 bit: write strobe for cw_word into the downstream FIFO.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse after the last codeword is written.

Function
REQ-015 SHALL transfer a bit only in a cycle with bin_valid=1 and bin_ready=1, at most one bit per cycle.
REQ-016 SHALL implement the states IDLE, PREFIX, SUFFIX, EMIT and FIN.
REQ-017 SHALL move from IDLE to PREFIX on start and clear the quotient q, remainder r, suffix count and word count.
REQ-018 SHALL, in PREFIX, increment q on each accepted 1 bit and go to SUFFIX on an accepted 0 bit; the 0 is consumed and q is unchanged.
REQ-019 SHALL, in PREFIX, go to SUFFIX in the cycle after q reaches QMAX, without consuming a terminating 0.
REQ-020 SHALL, in SUFFIX, accept exactly U bits MSB-first into r, then go to EMIT.
REQ-021 SHALL, in EMIT, drive cw_word = q*2^U + r and cw_wr=1 for exactly one cycle when fifo_full=0.
REQ-022 SHALL, in EMIT with fifo_full=1, hold cw_word, keep cw_wr=0 and keep bin_ready=0 until fifo_full=0.
REQ-023 SHALL, after each write, increment the word count and clear q and r.
REQ-024 SHALL, after the write, go to PREFIX if the word count is below NUM_WORDS, otherwise go to FIN.
REQ-025 SHALL, in FIN, pulse done=1 for one cycle and return to IDLE.
REQ-026 SHALL drive bin_ready=1 only in PREFIX (with q<QMAX) and in SUFFIX; bin_ready is registered or state-decoded with no combinational path from bin_valid.
REQ-027 SHALL ignore start in every state other than IDLE.
REQ-028 SHALL accept start and a bit in the same cycle in IDLE without consuming the bit; the first bit is taken in PREFIX.
REQ-029 SHALL hold state and counters unchanged when bin_valid=0 in PREFIX or SUFFIX (stall), with no timeout.
REQ-030 SHALL keep cw_word equal to the last written value outside EMIT.
REQ-031 SHALL size q at ceil(log2(QMAX+1)) bits, so that q cannot wrap.
REQ-032 SHALL size the word count at ceil(log2(NUM_WORDS+1)) bits.

Reset
REQ-033 SHALL, on rst_b=0, immediately force state=IDLE, q=r=0, all counters=0, cw_word=0, cw_wr=0, bin_ready=0 and done=0.
REQ-034 SHALL, on reset during a message, discard the partial word; no cw_wr and no done may follow until a new start.
REQ-035 SHALL release reset synchronously to clk so that no state update occurs in the release cycle.

Structure
REQ-036 SHALL place CW_W, U, QMAX and NUM_WORDS defaults and the state encoding in the shared package cw_pkg, which the decoder side also uses.
REQ-037 SHALL be a single module with no sub-module; the wrapper encoder_top, a separate block, instantiates it with fifo_10_to_10 on the output.

Verification
REQ-038 SHALL cover: bits 1,1,0 then 0,1,0,1 -> one cw_wr with cw_word=37 (q=2, r=5).
REQ-039 SHALL cover: bits 0 then 0,0,0,0 -> cw_word=0, with 5 bits consumed.
REQ-040 SHALL cover: 63 ones then 1,1,1,1 -> cw_word=1023, with 67 bits consumed, no terminating 0 taken and bin_ready low for one cycle at q=63.
REQ-041 SHALL cover: fifo_full=1 for 5 cycles during EMIT -> cw_wr=0 and bin_ready=0 for those 5 cycles, then a single cw_wr with the held value.
REQ-042 SHALL cover: a full message of 10 words with bin_valid toggling randomly -> exactly 10 cw_wr pulses and done one cycle after the 10th; a start pulsed mid-message has no effect.
REQ-043 SHALL cover: rst_b=0 asserted during SUFFIX of word 3 -> all outputs 0 immediately, and no cw_wr or done until the next start, after which the first word is correct.
